// File: rtl/tape_recorder.sv
// Oric cassette decoder: classifies rising-edge periods on tape_out into bits,
// assembles start + 8 data (LSB first) + odd parity frames and writes each byte.
module tape_recorder #(
  parameter int unsigned CLK_KHZ   = 24000,
  // Reset value of the write pointer; nonzero only to reach the cache-full boundary quickly.
  parameter logic [15:0] WPTR_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        tape_out,
  input  logic        rewind,
  output logic [15:0] tape_addr,
  output logic [7:0]  tape_data,
  output logic        tape_wr,
  output logic [15:0] tape_end,
  output logic        parity_err,
  output logic        active,
  output logic        full
);

  localparam int unsigned MINP_C   = CLK_KHZ * 104 / 1000;
  localparam int unsigned THRESH_C = CLK_KHZ * 312 / 1000;
  localparam int unsigned MAXP_C   = CLK_KHZ * 624 / 1000;

  localparam logic [15:0] MINP    = 16'(MINP_C);
  localparam logic [15:0] THRESH  = 16'(THRESH_C);
  localparam logic [15:0] MAXP    = 16'(MAXP_C);
  localparam logic [15:0] CNT_SAT = 16'(MAXP_C + 1);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    PARITY
  } state_t;

  state_t      state, state_d;
  logic        sync_q1, sync_q2, sync_prev;
  logic        rise;
  logic        have_ref;
  logic [15:0] period_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [15:0] wptr;
  logic        wr_q;

  logic        edge_start, resync, timeout, accept_edge;
  logic        bit_valid, bit_val;
  logic        shift_en, close_frame;
  logic        parity_ok;

  // tape_out is asynchronous to clk; sync_prev gives the edge detector a clean history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's pre-edge value;
      // blocking here would collapse the chain into a single flop.
      sync_q1   <= tape_out;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;
    end
  end

  assign rise = sync_q2 & ~sync_prev;

  // Period classification; a glitch edge falls through every branch and is ignored.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and infers a latch.
    edge_start = 1'b0;
    resync     = 1'b0;
    timeout    = 1'b0;
    bit_valid  = 1'b0;
    bit_val    = 1'b0;
    if (en && !rewind) begin
      if (rise) begin
        if (!have_ref) begin
          edge_start = 1'b1;
        end else if (period_cnt > MAXP) begin
          resync = 1'b1;
        end else if (period_cnt > THRESH) begin
          bit_valid = 1'b1;
          bit_val   = 1'b0;
        end else if (period_cnt >= MINP) begin
          bit_valid = 1'b1;
          bit_val   = 1'b1;
        end
      end else if (have_ref && period_cnt == CNT_SAT) begin
        timeout = 1'b1;
      end
    end
  end

  assign accept_edge = edge_start | resync | bit_valid;

  // Counter holds the cycles since the last accepted edge, so it reads p on the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_ref   <= 1'b0;
      period_cnt <= 16'd0;
    end else if (!en || rewind) begin
      have_ref   <= 1'b0;
      period_cnt <= 16'd0;
    end else if (accept_edge) begin
      have_ref   <= 1'b1;
      period_cnt <= 16'd1;
    end else if (timeout) begin
      have_ref   <= 1'b0;
      period_cnt <= 16'd0;
    end else if (have_ref && period_cnt != CNT_SAT) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HUNT;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    shift_en    = 1'b0;
    close_frame = 1'b0;
    if (!en || rewind || resync || timeout) begin
      state_d = HUNT;
    end else if (bit_valid) begin
      case (state)
        HUNT: begin
          if (!bit_val) begin
            state_d = DATA;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          close_frame = 1'b1;
          state_d     = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // bit_idx wraps 7 -> 0 on the last data bit, ready for the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
    end else if (state == HUNT) begin
      bit_idx <= 3'd0;
    end else if (shift_en) begin
      shreg   <= {bit_val, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Odd parity: data ones plus the parity bit must total an odd count.
  assign parity_ok = ^{shreg, bit_val};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= WPTR_INIT;
      parity_err <= 1'b0;
      wr_q       <= 1'b0;
      tape_addr  <= 16'h0000;
      tape_data  <= 8'h00;
    end else if (rewind) begin
      wptr       <= 16'h0000;
      parity_err <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (wr_q) begin
        wptr <= wptr + 16'd1;
      end
      if (close_frame) begin
        if (!parity_ok) begin
          parity_err <= 1'b1;
        end
        if (!full) begin
          wr_q      <= 1'b1;
          tape_addr <= wptr;
          tape_data <= shreg;
        end
      end
    end
  end

  // A rewind landing on the strobe cycle suppresses the write at the old address.
  assign tape_wr  = wr_q & ~rewind;
  assign tape_end = wptr;
  assign full     = &wptr;
  assign active   = (state != HUNT);

endmodule

// File: tb/tb_tape_recorder.sv
// Self-checking bench for tape_recorder: frame vector table with a write scoreboard,
// plus hand sequences for glitch, timeout gap, cache-full and rewind corners.
module tb_tape_recorder;

  // Scaled clock keeps frames short: MINP 104, THRESH 312, MAXP 624 cycles.
  localparam int CLK_KHZ = 1000;
  localparam int P1      = 208;
  localparam int P0      = 416;
  localparam int HIGH_T  = 20;
  localparam int GLITCH  = 42;
  localparam int IDLE    = 700;
  localparam int GAP     = 833;

  logic        clk, reset_n, en, en_f, tape_out, rewind, rewind_f;
  logic [15:0] tape_addr, tape_end, f_addr, f_end;
  logic [7:0]  tape_data, f_data;
  logic        tape_wr, parity_err, active, full;
  logic        f_wr, f_perr, f_active, f_full;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_perr;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         exp_fq[$];
  vec_t        vecs[5];
  logic [15:0] exp_addr;

  tape_recorder #(.CLK_KHZ(CLK_KHZ)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .tape_out(tape_out), .rewind(rewind),
    .tape_addr(tape_addr), .tape_data(tape_data), .tape_wr(tape_wr), .tape_end(tape_end),
    .parity_err(parity_err), .active(active), .full(full)
  );

  tape_recorder #(.CLK_KHZ(CLK_KHZ), .WPTR_INIT(16'hFFFE)) dut_full (
    .clk(clk), .reset_n(reset_n), .en(en_f), .tape_out(tape_out), .rewind(rewind_f),
    .tape_addr(f_addr), .tape_data(f_data), .tape_wr(f_wr), .tape_end(f_end),
    .parity_err(f_perr), .active(f_active), .full(f_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboards: every observed strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && tape_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: addr 0x%0h data 0x%0h, no write expected", tape_addr, tape_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(tape_addr), 32'(e.addr));
        check("wr_data", 32'(tape_data), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && f_wr) begin
      if (exp_fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_full_wr: addr 0x%0h data 0x%0h, no write expected", f_addr, f_data);
      end else begin
        wr_t e;
        e = exp_fq.pop_front();
        check("full_wr_addr", 32'(f_addr), 32'(e.addr));
        check("full_wr_data", 32'(f_data), 32'(e.data));
      end
    end
  end

  // Stimulus changes 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One rising edge followed by the period that encodes bit b.
  task automatic bit_period(input logic b, input logic glitch);
    int per;
    per = b ? P1 : P0;
    tape_out = 1'b1;
    tick(HIGH_T);
    tape_out = 1'b0;
    if (glitch) begin
      tick(20);
      tape_out = 1'b1;
      tick(GLITCH);
      tape_out = 1'b0;
      tick(per - HIGH_T - 20 - GLITCH);
    end else begin
      tick(per - HIGH_T);
    end
  endtask

  // Priming edge, start 0, data LSB first, parity; the closing edge is driven separately.
  task automatic send_body(input logic [7:0] d, input logic p, input int gidx);
    bit_period(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bit_period(d[i], i == gidx);
    end
    bit_period(p, 1'b0);
  endtask

  // Parity-closing edge: strobe must appear exactly in the third cycle after first sampling.
  task automatic final_edge(input logic exp_wr);
    tape_out = 1'b1;
    tick(2);
    @(negedge clk);
    check("wr_early", 32'(tape_wr), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wr_latency", 32'(tape_wr), 32'(exp_wr));
    tick(HIGH_T - 3);
    tape_out = 1'b0;
    tick(IDLE);
  endtask

  initial begin
    vecs[0] = '{data: 8'h16, par: 1'b0, exp_perr: 1'b0};
    vecs[1] = '{data: 8'hA5, par: 1'b1, exp_perr: 1'b0};
    vecs[2] = '{data: 8'hFF, par: 1'b1, exp_perr: 1'b0};
    vecs[3] = '{data: 8'h00, par: 1'b1, exp_perr: 1'b0};
    vecs[4] = '{data: 8'h24, par: 1'b0, exp_perr: 1'b1};

    reset_n  = 1'b0;
    en       = 1'b0;
    en_f     = 1'b0;
    tape_out = 1'b0;
    rewind   = 1'b0;
    rewind_f = 1'b0;
    exp_addr = 16'h0000;

    tick(4);
    check("rst_addr", 32'(tape_addr), 32'h0);
    check("rst_data", 32'(tape_data), 32'h0);
    check("rst_wr", 32'(tape_wr), 32'h0);
    check("rst_end", 32'(tape_end), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    reset_n = 1'b1;
    en      = 1'b1;
    tick(3);
    check("preload_end", 32'(f_end), 32'hFFFE);
    check("preload_full", 32'(f_full), 32'h0);

    // Frame table: each byte lands at the next address; 0x24 carries bad parity.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{addr: exp_addr, data: vecs[i].data});
      send_body(vecs[i].data, vecs[i].par, -1);
      final_edge(1'b1);
      exp_addr++;
      check("vec_perr", 32'(parity_err), 32'(vecs[i].exp_perr));
      check("vec_end", 32'(tape_end), 32'(exp_addr));
      check("vec_drained", exp_q.size(), 0);
      check("vec_idle", 32'(active), 32'h0);
    end

    // Glitch inside the 0-bit period of data bit 0; parity error stays sticky.
    exp_q.push_back('{addr: exp_addr, data: 8'h16});
    send_body(8'h16, 1'b0, 0);
    final_edge(1'b1);
    exp_addr++;
    check("glitch_end", 32'(tape_end), 32'(exp_addr));
    check("glitch_perr_sticky", 32'(parity_err), 32'h1);

    // Gap mid-DATA: partial byte dropped, next frame decodes cleanly.
    bit_period(1'b0, 1'b0);
    bit_period(1'b1, 1'b0);
    bit_period(1'b0, 1'b0);
    tape_out = 1'b1;
    tick(HIGH_T);
    tape_out = 1'b0;
    check("gap_active_before", 32'(active), 32'h1);
    tick(GAP);
    check("gap_active_after", 32'(active), 32'h0);
    check("gap_no_write", 32'(tape_end), 32'(exp_addr));
    exp_q.push_back('{addr: exp_addr, data: 8'h5A});
    send_body(8'h5A, 1'b1, -1);
    final_edge(1'b1);
    exp_addr++;
    check("gap_next_end", 32'(tape_end), 32'(exp_addr));

    // Cache-full boundary on the preloaded instance; main instance disabled and retains state.
    en   = 1'b0;
    en_f = 1'b1;
    tick(2);
    exp_fq.push_back('{addr: 16'hFFFE, data: 8'h3C});
    send_body(8'h3C, 1'b1, -1);
    final_edge(1'b0);
    check("full_end1", 32'(f_end), 32'hFFFF);
    check("full_flag1", 32'(f_full), 32'h1);
    check("full_drained", exp_fq.size(), 0);
    send_body(8'hC3, 1'b1, -1);
    final_edge(1'b0);
    check("full_end2", 32'(f_end), 32'hFFFF);
    check("full_flag2", 32'(f_full), 32'h1);
    check("dis_end_kept", 32'(tape_end), 32'(exp_addr));
    check("dis_perr_kept", 32'(parity_err), 32'h1);
    check("dis_active", 32'(active), 32'h0);
    en_f = 1'b0;
    en   = 1'b1;
    tick(2);

    // Rewind on the strobe cycle: no write at the old address.
    send_body(8'h99, 1'b1, -1);
    tape_out = 1'b1;
    tick(3);
    rewind = 1'b1;
    @(negedge clk);
    check("rewind_gates_wr", 32'(tape_wr), 32'h0);
    tick(1);
    rewind = 1'b0;
    tick(HIGH_T - 4);
    tape_out = 1'b0;
    tick(IDLE);
    check("rewind_end", 32'(tape_end), 32'h0);
    check("rewind_perr", 32'(parity_err), 32'h0);
    check("rewind_full", 32'(full), 32'h0);

    exp_addr = 16'h0000;
    exp_q.push_back('{addr: exp_addr, data: 8'h81});
    send_body(8'h81, 1'b1, -1);
    final_edge(1'b1);
    exp_addr++;
    check("after_rewind_end", 32'(tape_end), 32'(exp_addr));
    check("after_rewind_perr", 32'(parity_err), 32'h0);
    check("final_drained", exp_q.size() + exp_fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
